// File: rtl/mem_burst_master_if.sv
// mem_burst_master_if: single-beat memory command/response bus.
// Master drives valid/wr_rd/addr/wdata; the memory returns rdata/ready.
interface mem_burst_master_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
);

    logic              mem_valid_o;
    logic              mem_wr_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WIDTH-1:0]  mem_wdata_o;
    logic [WIDTH-1:0]  mem_rdata_i;
    logic              mem_ready_i;

    modport master (
        output mem_valid_o,
        output mem_wr_rd_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ready_i
    );

    modport slave (
        input  mem_valid_o,
        input  mem_wr_rd_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ready_i
    );

endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns one burst command into LEN single-beat accesses.
// Optional macro READ_CHECK_EN: compare read data against seed + beat index.
module mem_burst_master #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_wr_i,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [WIDTH-1:0]   cmd_seed_i,

    mem_burst_master_if.master mem,

    output logic [WIDTH-1:0]   rd_data_o,
    output logic               rd_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               mismatch_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;

    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;

    logic              r_mem_valid;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WIDTH-1:0]  r_mem_wdata;

    logic [LEN_W-1:0]  r_left;
    logic              r_wr;

    logic              r_pend;
    logic              r_err;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;

    logic              w_accept;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_accept    = cmd_valid_i && r_cmd_ready;
    assign w_last_beat = (r_left == '0);

    // Address wraps from DEPTH-1 back to 0 even when DEPTH is not 2^ADDR_W.
    assign w_next_addr = (r_mem_addr == ADDR_W'(DEPTH - 1))
                       ? '0
                       : r_mem_addr + ADDR_W'(1);

    // Burst sequencer: IDLE -> ISSUE (len beats) -> DRAIN -> DONE -> IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_left      <= '0;
            r_wr        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wr        <= cmd_wr_i;
                        r_mem_addr  <= cmd_addr_i;
                        r_mem_wdata <= cmd_seed_i;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len_i != '0) begin
                            r_state     <= S_ISSUE;
                            r_mem_valid <= 1'b1;
                            r_mem_wr    <= cmd_wr_i;
                            r_left      <= cmd_len_i - LEN_W'(1);
                        end else begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_left      <= '0;
                        end
                    end
                end

                S_ISSUE: begin
                    if (w_last_beat) begin
                        r_state     <= S_DRAIN;
                        r_mem_valid <= 1'b0;
                        r_mem_wr    <= 1'b0;
                    end else begin
                        r_left      <= r_left - LEN_W'(1);
                        r_mem_addr  <= w_next_addr;
                        r_mem_wdata <= r_mem_wdata + WIDTH'(1);
                    end
                end

                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end

                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Response side: a beat issued last cycle is answered this cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_pend     <= r_mem_valid;
            r_rd_valid <= r_pend && !r_wr;
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (r_pend && !mem.mem_ready_i) begin
                r_err <= 1'b1;
            end
            if (r_pend && !r_wr) begin
                r_rd_data <= mem.mem_rdata_i;
            end
        end
    end

`ifdef READ_CHECK_EN
    logic [WIDTH-1:0] r_exp;
    logic             r_mismatch;

    // Expected pattern trails the issued wdata by one cycle, like rdata.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_exp      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_exp <= r_mem_wdata;
            if (w_accept) begin
                r_mismatch <= 1'b0;
            end else if (r_pend && !r_wr
                         && (mem.mem_rdata_i != r_exp)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch_o = r_mismatch;
`else
    assign mismatch_o = 1'b0;
`endif

    assign cmd_ready_o     = r_cmd_ready;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;
    assign rd_data_o       = r_rd_data;
    assign rd_valid_o      = r_rd_valid;

    assign mem.mem_valid_o = r_mem_valid;
    assign mem.mem_wr_rd_o = r_mem_wr;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: table, corner-case and random bursts against a
// stub memory, checked with an array model of the memory contents.
module tb_mem_burst_master;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [5:0]  cmd_addr;
    logic [6:0]  cmd_len;
    logic [15:0] cmd_seed;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic        mismatch;

    int total = 0;
    int bad   = 0;

    mem_burst_master_if #(.WIDTH(16), .ADDR_W(6)) bus ();

    mem_burst_master #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_wr_i    (cmd_wr),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .cmd_seed_i  (cmd_seed),
        .mem         (bus),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .mismatch_o  (mismatch)
    );

    always #5 clk = ~clk;

    // Stub memory: one beat per valid edge, ready/rdata the next cycle.
    logic [15:0] smem [DEPTH] = '{default: 16'h0};
    int beat_cnt = 0;
    int stall_at = -1;

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) beat_cnt <= 0;
        else if (bus.mem_valid_o) beat_cnt <= beat_cnt + 1;
        if (bus.mem_valid_o) begin
            if (bus.mem_wr_rd_o) smem[bus.mem_addr_o] <= bus.mem_wdata_o;
            else bus.mem_rdata_i <= smem[bus.mem_addr_o];
        end
        bus.mem_ready_i <= bus.mem_valid_o && (beat_cnt != stall_at);
    end

    // Reference contents of the memory, updated from command semantics.
    logic [15:0] mdl [DEPTH];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input bit wr, input int addr, input int len,
                           input int seed, input int stall,
                           output int o_busy, output int o_rdn,
                           output bit o_err);
        int          ea[$];
        logic [15:0] ew[$];
        logic [15:0] er[$];
        int          oa[$];
        logic [15:0] ow[$];
        logic [15:0] orr[$];
        bit mis_exp  = 0;
        bit mis_want;
        bit err_exp;
        bit got_done = 0;
        bit rdv_done = 0;
        bit err_done = 0;
        bit mis_done = 0;
        int nbusy = 0;
        int ndone = -1;
        int nlast = -1;
        int wr_bad = 0;
        int nbad = 0;

        for (int k = 0; k < len; k++) begin
            int a;
            a = (addr + k) % DEPTH;
            ea.push_back(a);
            ew.push_back(16'(seed + k));
            if (wr) begin
                mdl[a] = 16'(seed + k);
            end else begin
                er.push_back(mdl[a]);
                if (mdl[a] != 16'(seed + k)) mis_exp = 1;
            end
        end
        err_exp = (stall >= 0) && (stall < len);
`ifdef READ_CHECK_EN
        mis_want = mis_exp;
`else
        mis_want = 1'b0 & mis_exp;
`endif

        stall_at  = stall;
        cmd_wr    = wr;
        cmd_addr  = 6'(addr);
        cmd_len   = 7'(len);
        cmd_seed  = 16'(seed);
        cmd_valid = 1'b1;
        check("ready_in_idle", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("clear_on_accept", {err, mismatch}, 0);

        for (int n = 0; n < 200; n++) begin
            if (bus.mem_valid_o) begin
                oa.push_back(bus.mem_addr_o);
                ow.push_back(bus.mem_wdata_o);
                if (bus.mem_wr_rd_o != wr) wr_bad++;
                nlast = n;
            end
            if (rd_valid) orr.push_back(rd_data);
            if (busy) nbusy++;
            if (done) begin
                got_done = 1;
                ndone    = n;
                rdv_done = rd_valid;
                err_done = err;
                mis_done = mismatch;
                break;
            end
            @(negedge clk);
        end

        check("done_seen", got_done, 1);
        check("beat_count", oa.size(), len);
        for (int k = 0; k < oa.size() && k < len; k++)
            if (oa[k] != ea[k] || ow[k] != ew[k]) nbad++;
        check("beat_addr_data", nbad, 0);
        check("beat_wr_rd", wr_bad, 0);
        check("busy_cycles", nbusy, (len == 0) ? 1 : len + 2);
        check("done_cycle", ndone, (len == 0) ? 0 : len + 1);
        if (len > 0) check("done_after_valid", ndone - nlast, 2);
        check("rd_count", orr.size(), er.size());
        nbad = 0;
        for (int k = 0; k < orr.size() && k < er.size(); k++)
            if (orr[k] != er[k]) nbad++;
        check("rd_data", nbad, 0);
        if (!wr && len > 0) check("rd_last_at_done", rdv_done, 1);
        check("err_at_done", err_done, err_exp);
        check("mismatch_at_done", mis_done, mis_want);

        @(negedge clk);
        check("idle_after", {busy, cmd_ready, done}, 3'b010);
        check("err_sticky", err, err_exp);
        stall_at = -1;
        o_busy = nbusy;
        o_rdn  = orr.size();
        o_err  = err_done;
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        int seed;
        int stall;
        int exp_busy;
        int exp_rdn;
        bit exp_err;
    } vec_t;

    vec_t tbl[10];

    int          ob;
    int          orn;
    bit          oe;
    int          nv;
    int          nd;
    bit          hv[13];
    logic [5:0]  ha[13];
    logic [15:0] hw[13];
    bit          hd[13];
    bit          hr[13];
    bit          rw;
    int          ra;
    int          rl;
    int          rs;
    int          rst_k;

    initial begin
        tbl[0] = '{1, 4,  4,  'h0100, -1, 6,  0, 0};
        tbl[1] = '{1, 62, 4,  'hFFFE, -1, 6,  0, 0};
        tbl[2] = '{0, 62, 4,  'hFFFE, -1, 6,  4, 0};
        tbl[3] = '{0, 62, 4,  'h0000, -1, 6,  4, 0};
        tbl[4] = '{0, 10, 0,  'h0000, -1, 1,  0, 0};
        tbl[5] = '{0, 10, 3,  'h0000, 1,  5,  3, 1};
        tbl[6] = '{0, 11, 2,  'h0000, -1, 4,  2, 0};
        tbl[7] = '{1, 0,  64, 'h1234, -1, 66, 0, 0};
        tbl[8] = '{1, 5,  65, 'h7000, -1, 67, 0, 0};
        tbl[9] = '{0, 3,  5,  'h7000, -1, 7,  5, 0};

        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_seed  = '0;

        repeat (3) @(negedge clk);
        check("reset_state",
              {cmd_ready, busy, done, bus.mem_valid_o, rd_valid, err,
               mismatch}, 7'b1000000);
        rst = 1'b1;
        @(negedge clk);

        cmd_wr    = 1'b1;
        cmd_addr  = 6'd40;
        cmd_len   = 7'd8;
        cmd_seed  = 16'h5000;
        cmd_valid = 1'b1;
        @(posedge clk);
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (bus.mem_valid_o) nv++;
        end
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_burst",
              {bus.mem_valid_o, busy, cmd_ready, done}, 4'b0010);
        rst = 1'b1;
        nd  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("reset_no_done", nd, 0);
        check("reset_beats_issued", nv, 3);
        for (int k = 0; k < nv; k++) mdl[(40 + k) % DEPTH] = 16'(16'h5000 + k);

        for (int i = 0; i < 10; i++) begin
            run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].seed,
                    tbl[i].stall, ob, orn, oe);
            check("tbl_busy", ob, tbl[i].exp_busy);
            check("tbl_rd_count", orn, tbl[i].exp_rdn);
            check("tbl_err", oe, tbl[i].exp_err);
        end

        cmd_wr    = 1'b1;
        cmd_addr  = 6'd20;
        cmd_len   = 7'd2;
        cmd_seed  = 16'h0AAA;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_addr = 6'd30;
        cmd_len  = 7'd3;
        cmd_seed = 16'h0BBB;
        for (int n = 0; n < 13; n++) begin
            hv[n] = bus.mem_valid_o;
            ha[n] = bus.mem_addr_o;
            hw[n] = bus.mem_wdata_o;
            hd[n] = done;
            hr[n] = cmd_ready;
            if (n == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
        check("hold_a_beats",
              {hv[0], hv[1], ha[0], ha[1], hw[0][3:0], hw[1][3:0]},
              {1'b1, 1'b1, 6'd20, 6'd21, 4'hA, 4'hB});
        check("hold_a_wdata", hw[0], 16'h0AAA);
        check("hold_gap", {hv[2], hv[3], hv[4]}, 3'b000);
        check("hold_a_done", {hd[2], hd[3], hd[4]}, 3'b010);
        check("hold_ready", {hr[3], hr[4], hr[5]}, 3'b010);
        check("hold_b_first", {hv[5], ha[5], hw[5]}, {1'b1, 6'd30, 16'h0BBB});
        check("hold_b_done", {hd[8], hd[9]}, 2'b01);
        mdl[20] = 16'h0AAA;
        mdl[21] = 16'h0AAB;
        mdl[30] = 16'h0BBB;
        mdl[31] = 16'h0BBC;
        mdl[32] = 16'h0BBD;

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = int'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) rl = int'($urandom_range(60, 70));
            else rl = int'($urandom_range(0, 8));
            rs = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0)
                rst_k = int'($urandom_range(0, 32'(rl + 1)));
            else
                rst_k = -1;
            run_cmd(rw, ra, rl, rs, rst_k, ob, orn, oe);
            if (rw && $urandom_range(0, 1) == 1)
                run_cmd(1'b0, ra, rl, rs, -1, ob, orn, oe);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Upstream command stage for the single-port `memory` block. Converts one burst command into LEN back-to-back single-beat transactions on the memory's valid/wr_rd/addr/wdata interface.
- Write bursts carry a generated pattern: data = seed + beat index.
- Read bursts return memory data as a registered output stream.
- Used as the bring-up/traffic master in front of the memory array.

Parameters:
- WIDTH, 16, data width; matches the memory WIDTH.
- DEPTH, 64, memory depth in words.
- ADDR_W, $clog2(DEPTH), address width.
- LEN_W, ADDR_W+1, burst length field width; legal length range is 0..DEPTH.

Ports:
- clk_i  input  1  clock, all logic on the rising edge.
- rst_i  input  1  synchronous reset, active-low.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  high only in IDLE; command accepted when cmd_valid_i && cmd_ready_o at the edge.
- cmd_wr_i  input  1  1 = write burst, 0 = read burst.
- cmd_addr_i  input  ADDR_W  burst start address.
- cmd_len_i  input  LEN_W  number of beats.
- cmd_seed_i  input  WIDTH  pattern seed.
- mem_valid_o  output  1  drives memory valid_i.
- mem_wr_rd_o  output  1  drives memory wr_rd_i.
- mem_addr_o  output  ADDR_W  drives memory addr_i.
- mem_wdata_o  output  WIDTH  drives memory wdata_i.
- mem_rdata_i  input  WIDTH  from memory rdata_o.
- mem_ready_i  input  1  from memory ready_o.
- rd_data_o  output  WIDTH  read stream data.
- rd_valid_o  output  1  one-cycle qualifier per read beat; no backpressure.
- busy_o  output  1  high whenever the state is not IDLE.
- done_o  output  1  one-cycle pulse at burst end.
- err_o  output  1  sticky handshake error.
- mismatch_o  output  1  sticky read-compare error (see Optional Feature).

Behaviour:
- Reset (rst_i==0 at an edge), regardless of state:
  - State goes to IDLE.
  - All outputs 0 except cmd_ready_o=1.
  - Internal counters and latched command fields cleared.
- Memory contract relied on:
  - The memory executes a beat at every edge where valid is sampled high.
  - For a beat issued in cycle t, mem_ready_i=1 in cycle t+1; on a read, mem_rdata_i is valid in cycle t+1.
- States:
  - IDLE:
    - cmd_ready_o=1.
    - On accept, latch wr, addr, len and seed.
    - Go to ISSUE if len!=0, else DONE.
    - Clear err_o and mismatch_o on every accept.
  - ISSUE, exactly len cycles:
    - mem_valid_o=1; mem_wr_rd_o = latched wr.
    - mem_addr_o = (base + k) mod DEPTH; the address wraps from DEPTH-1 to 0.
    - mem_wdata_o = (seed + k) mod 2^WIDTH, where k = 0..len-1 is the beat index.
    - One beat per cycle, with no gaps.
    - After beat len-1, go to DRAIN.
  - DRAIN, 1 cycle: mem_valid_o=0; collects the last beat response.
  - DONE, 1 cycle: done_o=1, then back to IDLE.
- Output timing:
  - mem_* outputs are registered.
  - mem_valid_o is high for exactly len consecutive cycles.
  - For len>0, busy_o is high for len+2 cycles after accept.
- Response collection: in each cycle from ISSUE beat 1 through DRAIN (len cycles in total):
  - mem_ready_i must be 1. If it is 0, set err_o; it stays set until the next accept.
  - On a read burst, register mem_rdata_i into rd_data_o and pulse rd_valid_o in the following cycle.
  - Read beat k therefore appears 2 cycles after it was issued. The last rd_valid_o coincides with done_o.
- Write bursts never assert rd_valid_o.
- cmd_valid_i while busy is ignored; the command is not queued.
- len > DEPTH is not a legal command: the burst still runs len beats, and addresses wrap.

Optional Feature:
- Macro READ_CHECK_EN.
- Defined:
  - On each read beat k, compare mem_rdata_i against (seed + k) mod 2^WIDTH.
  - Any difference sets mismatch_o (sticky, cleared on accept).
  - This checks a write-then-read with the same seed.
- Undefined: no compare logic is built; mismatch_o is tied to 0.

Test Plan:
- Reset mid-burst: rst_i=0 during ISSUE of a len=8 write -> next cycle mem_valid_o=0, busy_o=0, cmd_ready_o=1, done_o never pulses.
- Write burst: wr=1, addr=4, len=4, seed=0x0100 -> mem_valid_o high 4 cycles, addr 4,5,6,7, wdata 0x0100..0x0103, done_o 2 cycles after the last valid, no rd_valid_o.
- Read-back wrap burst, after a write of addr=62, len=4, seed=0xFFFE:
  - Stimulus: read addr=62, len=4.
  - Expect addresses 62,63,0,1.
  - Expect rd_data_o 0xFFFE,0xFFFF,0x0000,0x0001 on 4 consecutive rd_valid_o cycles.
  - With READ_CHECK_EN: mismatch_o=0. Read again with seed=0 -> mismatch_o=1.
- len=0 command -> no mem_valid_o, done_o one cycle after accept, busy_o high exactly 1 cycle.
- Stub memory holds mem_ready_i=0 in beat 2 of a len=3 read -> err_o=1, and still 1 after done_o. The next command accept clears it.
- cmd_valid_i held high across a len=2 burst with changed fields -> second command accepted only in IDLE after done_o, using the fields present at that edge.
